// File: rtl/fold_sig_accum.sv
// rtl/fold_sig_accum.sv - rotate-XOR frame signature accumulator with hold handshake
// Define FOLD_SIG_CNT_EN to add the saturating beat_cnt output.
module fold_sig_accum #(
  parameter logic [7:0] SEED_A = 8'hA5,
  parameter logic [7:0] SEED_B = 8'h5A
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_aa,
  input  logic [7:0] in_bb,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] sig_a,
  output logic [7:0] sig_b
`ifdef FOLD_SIG_CNT_EN
  ,
  output logic [7:0] beat_cnt
`endif
);

  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_HOLD  = 1'b1;

  logic [0:0] state_q, state_d;
  logic       in_ready_q, in_ready_d;
  logic [7:0] sig_a_q, sig_a_d;
  logic [7:0] sig_b_q, sig_b_d;

  function automatic logic [7:0] rotl1(input logic [7:0] x);
    return {x[6:0], x[7]};
  endfunction

  always_comb begin
    state_d = state_q;
    sig_a_d = sig_a_q;
    sig_b_d = sig_b_q;
    case (state_q)
      ST_ACCUM: begin
        if (in_valid) begin
          sig_a_d = rotl1(sig_a_q) ^ in_aa;
          sig_b_d = rotl1(sig_b_q) ^ in_bb;
          if (in_last) state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          state_d = ST_ACCUM;
          sig_a_d = SEED_A;
          sig_b_d = SEED_B;
        end
      end
    endcase
    // in_ready is its own flop so the output never decodes state combinationally
    in_ready_d = (state_d == ST_ACCUM);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_ACCUM;
      in_ready_q <= 1'b1;
      sig_a_q    <= SEED_A;
      sig_b_q    <= SEED_B;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      sig_a_q    <= sig_a_d;
      sig_b_q    <= sig_b_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = state_q[0];
  assign sig_a     = sig_a_q;
  assign sig_b     = sig_b_q;

`ifdef FOLD_SIG_CNT_EN
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_ACCUM) begin
      if (in_valid && (cnt_q != 8'hFF)) cnt_d = cnt_q + 8'd1;
    end else if (out_ready) begin
      cnt_d = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= 8'd0;
    else     cnt_q <= cnt_d;
  end

  assign beat_cnt = cnt_q;
`endif

endmodule
